// File: rtl/alu_pkg.sv
// Shared op codes and FSM state type for multicycle_alu.
// MUL_BUSY exists only when ALU_MUL_EN is defined.
package alu_pkg;

  localparam logic [3:0] OP_NOOP = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_SHL  = 4'b0100;
  localparam logic [3:0] OP_SHR  = 4'b0101;
  localparam logic [3:0] OP_ADDI = 4'b0110;
  localparam logic [3:0] OP_SUBI = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_AND  = 4'b1001;
  localparam logic [3:0] OP_OR   = 4'b1010;
  localparam logic [3:0] OP_XOR  = 4'b1011;
  localparam logic [3:0] OP_MUL  = 4'b1100;

`ifdef ALU_MUL_EN
  typedef enum logic {IDLE = 1'b0, MUL_BUSY = 1'b1} state_t;
`else
  typedef enum logic {IDLE = 1'b0} state_t;
`endif

endpackage

// File: rtl/shift_add_multiplier.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle; low WIDTH product bits.
// done is high for one cycle, WIDTH+1 cycles after start; start is ignored while busy.
module shift_add_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;

  assign done    = busy && (cnt == CNT_W'(WIDTH));
  assign product = acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start && !busy) begin
      busy   <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (busy) begin
      if (done) begin
        busy <= 1'b0;
      end else begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// Valid/ready ALU: single-cycle ops at latency 1; MUL (only with ALU_MUL_EN) iterates for WIDTH+1 cycles.
// Result is held while out_ready is low; a new request is taken only when the output slot drains.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);

  localparam int SHAMT_W = $clog2(WIDTH);

  state_t             state;
  state_t             state_next;
  logic               accept;
  logic               is_mul;
  logic               mul_busy;
  logic               mul_done;
  logic [WIDTH-1:0]   mul_product;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ill;
  logic [SHAMT_W-1:0] shamt;

  assign shamt  = src_b[SHAMT_W-1:0];
  assign accept = in_valid && in_ready;

`ifdef ALU_MUL_EN
  assign is_mul = (op == OP_MUL);

  shift_add_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (accept && is_mul),
    .a       (src_a),
    .b       (src_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign is_mul      = 1'b0;
  assign mul_busy    = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
`ifdef ALU_MUL_EN
    case (state)
      IDLE:     if (accept && is_mul) state_next = MUL_BUSY;
      MUL_BUSY: if (mul_done)         state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
`endif
  end

  always_comb begin
    in_ready = (state == IDLE) && !mul_busy && (!out_valid || out_ready);
  end

  // Unsupported codes (and MUL when the multiplier is not built) fall to default.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (op)
      OP_NOOP:         alu_res = '0;
      OP_ADD, OP_ADDI: alu_res = src_a + src_b;
      OP_SUB, OP_SUBI: alu_res = src_a - src_b;
      OP_SHL:          alu_res = src_a << shamt;
      OP_SHR:          alu_res = src_a >> shamt;
      OP_SRA:          alu_res = $signed(src_a) >>> shamt;
      OP_AND:          alu_res = src_a & src_b;
      OP_OR:           alu_res = src_a | src_b;
      OP_XOR:          alu_res = src_a ^ src_b;
      default:         alu_ill = 1'b1;
    endcase
  end

  // Accepting a request implies the slot is empty or draining this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      illegal   <= 1'b0;
    end else if (accept && !is_mul) begin
      out_valid <= 1'b1;
      result    <= alu_res;
      illegal   <= alu_ill;
    end else if (mul_done) begin
      out_valid <= 1'b1;
      result    <= mul_product;
      illegal   <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand and result width; legal values are 8..64.
REQ-002 Derived constant SHAMT_W SHALL equal clog2(WIDTH) and size the shift amount.
REQ-003 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 op  input  4  operation code.
REQ-008 src_a  input  WIDTH  first operand.
REQ-009 src_b  input  WIDTH  second operand or shift amount.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 result  output  WIDTH  registered result.
REQ-013 illegal  output  1  registered flag; set with result when op was unsupported.

Function
REQ-014 Op codes SHALL be: NOOP 0000, ADD 0010, SUB 0011, SHL 0100, SHR 0101, ADDI 0110, SUBI 0111, SRA 1000, AND 1001, OR 1010, XOR 1011, MUL 1100; all others are illegal.
REQ-015 A request SHALL be accepted on a rising edge where in_valid and in_ready are both 1; operands and op are captured at that edge.
REQ-016 in_ready SHALL be 1 only in state IDLE and only when out_valid is 0 or out_ready is 1.
REQ-017 The FSM SHALL have states IDLE and MUL_BUSY: IDLE goes to MUL_BUSY on accepting a MUL; MUL_BUSY returns to IDLE after WIDTH iteration cycles.
REQ-018 Single-cycle ops (all except MUL) SHALL assert out_valid on the edge after acceptance (latency 1).
REQ-019 MUL SHALL be iterative shift-add, one multiplier bit per cycle; out_valid SHALL rise exactly WIDTH+1 cycles after acceptance.
REQ-020 ADD/ADDI SHALL compute src_a+src_b modulo 2^WIDTH, and SUB/SUBI src_a-src_b modulo 2^WIDTH, with no carry or overflow output.
REQ-021 SHL/SHR/SRA SHALL shift src_a by src_b[SHAMT_W-1:0]; SRA replicates the sign bit, and upper bits of src_b are ignored.
REQ-022 MUL SHALL return the low WIDTH bits of the unsigned product.
REQ-023 NOOP SHALL return result 0 with illegal 0; an illegal op SHALL return result 0 with illegal 1, both at latency 1.
REQ-024 While out_valid=1 and out_ready=0, result, illegal and out_valid SHALL hold stable.
REQ-025 out_valid SHALL clear on the edge where out_ready=1, unless a new single-cycle result is loaded at that same edge (back-to-back throughput of 1 per cycle).
REQ-026 During MUL_BUSY, in_ready SHALL be 0 and in_valid SHALL be ignored.

Reset
REQ-027 On reset: state IDLE, out_valid 0, result 0, illegal 0, multiplier accumulator and counter 0.
REQ-028 Reset asserted mid-MUL SHALL abort the operation with no result produced; in_ready SHALL be 1 on the first cycle after reset deasserts.

Configuration
REQ-029 Macro ALU_MUL_EN defined: MUL SHALL be implemented per REQ-019/022.
REQ-030 ALU_MUL_EN undefined: no multiplier logic or MUL_BUSY state SHALL exist, and op 1100 SHALL be treated as illegal per REQ-023.

Structure
REQ-031 A shared package alu_pkg SHALL hold the op-code constants and the FSM state typedef.
REQ-032 The iterative multiplier SHALL be a sub-module shift_add_multiplier (start/busy/done interface), instantiated only under ALU_MUL_EN.

Verification
REQ-033 ADD with 0xFFFFFFFF and 0x00000001, out_ready=1 -> result 0x00000000, illegal 0, out_valid one cycle after acceptance.
REQ-034 SRA with 0x80000000 and src_b=0x00000024 -> result 0xF8000000 (shift amount 4).
REQ-035 MUL (ALU_MUL_EN) with 0x00010003 and 0x00020005 -> result 0x000B000F, out_valid at acceptance+33, in_ready 0 throughout.
REQ-036 op 1111, then ADD 2+3 held with out_ready=0 for 5 cycles -> illegal=1 with result 0; the second result 5 stays stable while out_ready=0; in_ready stays 0 while the held result is not drained.
REQ-037 Reset pulse 10 cycles into a MUL -> out_valid never rises for that MUL; next ADD 1+1 returns 2.
REQ-038 Build without ALU_MUL_EN, MUL 3*4 -> result 0, illegal 1, latency 1.
